// File: rtl/divsqrt_rr_arbiter_pkg.sv
// Shared types for the div/sqrt round-robin arbiter.
// Widths of the recoded FP64 datapath, FSM states, response bundle.
package divsqrt_arb_pkg;

  localparam int REC_W = 65;
  localparam int RM_W  = 3;
  localparam int EXC_W = 5;

  // Widest id/tag the response bundle can carry (NUM_REQ<=8, TAG_W<=16).
  localparam int ID_MAX_W  = 3;
  localparam int TAG_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ID_MAX_W-1:0]  id;
    logic [TAG_MAX_W-1:0] tag;
    logic                 is_sqrt;
    logic [REC_W-1:0]     data;
    logic [EXC_W-1:0]     exc;
  } resp_t;

endpackage

// File: rtl/divsqrt_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping. Ports: req_i, ptr_i -> gnt_o (one-hot), idx_o, any_o.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/divsqrt_rr_arbiter.sv
// Shares one iterative recoded-FP64 div/sqrt unit among NUM_REQ requesters.
// Ports: clock, reset (sync, active-low); req_* (packed per requester),
// unit_* (to/from DivSqrtRecFN_small), flush, resp_* valid/ready channel,
// busy, protocol_err (sticky). Optional watchdog: DIVSQRT_ARB_TIMEOUT_EN.
module divsqrt_rr_arbiter
  import divsqrt_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_sqrt,
  input  logic [NUM_REQ*REC_W-1:0] req_a,
  input  logic [NUM_REQ*REC_W-1:0] req_b,
  input  logic [NUM_REQ*RM_W-1:0]  req_rm,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic                     unit_in_ready,
  output logic                     unit_in_valid,
  output logic                     unit_sqrt,
  output logic [REC_W-1:0]         unit_a,
  output logic [REC_W-1:0]         unit_b,
  output logic [RM_W-1:0]          unit_rm,
  input  logic                     unit_out_valid_div,
  input  logic                     unit_out_valid_sqrt,
  input  logic [REC_W-1:0]         unit_out,
  input  logic [EXC_W-1:0]         unit_exc,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [TAG_W-1:0]         resp_tag,
  output logic                     resp_is_sqrt,
  output logic [REC_W-1:0]         resp_data,
  output logic [EXC_W-1:0]         resp_exc,
  output logic                     busy,
  output logic                     protocol_err
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   own_id_q, own_id_d;
  logic [TAG_W-1:0]  own_tag_q, own_tag_d;
  logic              own_sqrt_q, own_sqrt_d;
  logic              drop_q, drop_d;
  logic              rvalid_q, rvalid_d;
  logic              perr_q, perr_d;
  resp_t             resp_q, resp_d;
  resp_t             cap;

  logic [NUM_REQ-1:0] pick_gnt, gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               idle, fire, out_v, out_bad, tmo;
  logic [TAG_W-1:0]   sel_tag;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign idle          = (state_q == IDLE);
  assign gnt           = idle ? pick_gnt : '0;
  assign unit_in_valid = idle & pick_any & ~flush;
  assign fire          = unit_in_valid & unit_in_ready;
  assign req_ready     = fire ? gnt : '0;

  always_comb begin
    unit_sqrt = 1'b0;
    unit_a    = '0;
    unit_b    = '0;
    unit_rm   = '0;
    sel_tag   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        unit_sqrt = req_sqrt[i];
        unit_a    = req_a[i*REC_W +: REC_W];
        unit_b    = req_b[i*REC_W +: REC_W];
        unit_rm   = req_rm[i*RM_W +: RM_W];
        sel_tag   = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign out_v   = unit_out_valid_div | unit_out_valid_sqrt;
  // Wrong completion type, or both types at once, is a unit protocol error.
  assign out_bad = (unit_out_valid_div & unit_out_valid_sqrt)
                 | (unit_out_valid_div & own_sqrt_q)
                 | (unit_out_valid_sqrt & ~own_sqrt_q);

`ifdef DIVSQRT_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo   = (state_q == BUSY) & ~out_v
               & (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d = ((state_q == BUSY) && (state_d == BUSY))
               ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  assign tmo        = 1'b0;
  assign unused_cfg = (TIMEOUT != 0);
`endif

  // A watchdog expiry delivers a synthetic invalid-operation response.
  always_comb begin
    cap                  = '0;
    cap.id[ID_W-1:0]     = own_id_q;
    cap.tag[TAG_W-1:0]   = own_tag_q;
    cap.is_sqrt          = own_sqrt_q;
    cap.data             = tmo ? '0 : unit_out;
    cap.exc              = tmo ? 5'b10000 : unit_exc;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    own_id_d   = own_id_q;
    own_tag_d  = own_tag_q;
    own_sqrt_d = own_sqrt_q;
    drop_d     = drop_q;
    rvalid_d   = rvalid_q;
    perr_d     = perr_q;
    resp_d     = resp_q;
    unique case (state_q)
      IDLE: begin
        if (out_v) perr_d = 1'b1;
        if (fire) begin
          own_id_d   = pick_idx;
          own_tag_d  = sel_tag;
          own_sqrt_d = unit_sqrt;
          rr_ptr_d   = (pick_idx == ID_W'(NUM_REQ - 1))
                     ? '0 : pick_idx + 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (out_v && out_bad) perr_d = 1'b1;
        if (tmo) perr_d = 1'b1;
        if (out_v || tmo) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            resp_d   = cap;
            rvalid_d = 1'b1;
            state_d  = RESP;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      RESP: begin
        if (out_v) perr_d = 1'b1;
        if (flush || resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      own_id_q   <= '0;
      own_tag_q  <= '0;
      own_sqrt_q <= 1'b0;
      drop_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      perr_q     <= 1'b0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      own_id_q   <= own_id_d;
      own_tag_q  <= own_tag_d;
      own_sqrt_q <= own_sqrt_d;
      drop_q     <= drop_d;
      rvalid_q   <= rvalid_d;
      perr_q     <= perr_d;
      resp_q     <= resp_d;
    end
  end

  logic unused_resp;
  assign unused_resp  = ^{resp_q.id, resp_q.tag};

  assign resp_valid   = rvalid_q;
  assign resp_id      = resp_q.id[ID_W-1:0];
  assign resp_tag     = resp_q.tag[TAG_W-1:0];
  assign resp_is_sqrt = resp_q.is_sqrt;
  assign resp_data    = resp_q.data;
  assign resp_exc     = resp_q.exc;
  assign busy         = (state_q != IDLE);
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_divsqrt_rr_arbiter.sv
// Directed self-checking bench for divsqrt_rr_arbiter (NUM_REQ=2).
// The bench plays the role of the div/sqrt unit.
module tb_divsqrt_rr_arbiter;

  localparam int N  = 2;
  localparam int TW = 5;

  localparam logic [64:0] ONE  = 65'h0_8000_0000_0000_0000;
  localparam logic [64:0] TWO  = 65'h0_8010_0000_0000_0000;
  localparam logic [64:0] HALF = 65'h0_7FF0_0000_0000_0000;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_sqrt = '0;
  logic [N*65-1:0] req_a = '0;
  logic [N*65-1:0] req_b = '0;
  logic [N*3-1:0] req_rm = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic           unit_in_ready = 1'b1;
  logic           unit_in_valid, unit_sqrt;
  logic [64:0]    unit_a, unit_b;
  logic [2:0]     unit_rm;
  logic           unit_out_valid_div = 1'b0;
  logic           unit_out_valid_sqrt = 1'b0;
  logic [64:0]    unit_out = '0;
  logic [4:0]     unit_exc = '0;
  logic           flush = 1'b0;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [0:0]     resp_id;
  logic [TW-1:0]  resp_tag;
  logic           resp_is_sqrt;
  logic [64:0]    resp_data;
  logic [4:0]     resp_exc;
  logic           busy, protocol_err;

  int n_cmp = 0;
  int n_err = 0;

  divsqrt_rr_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sqrt(req_sqrt), .req_a(req_a), .req_b(req_b),
    .req_rm(req_rm), .req_tag(req_tag),
    .unit_in_ready(unit_in_ready), .unit_in_valid(unit_in_valid),
    .unit_sqrt(unit_sqrt), .unit_a(unit_a), .unit_b(unit_b),
    .unit_rm(unit_rm),
    .unit_out_valid_div(unit_out_valid_div),
    .unit_out_valid_sqrt(unit_out_valid_sqrt),
    .unit_out(unit_out), .unit_exc(unit_exc),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_tag(resp_tag),
    .resp_is_sqrt(resp_is_sqrt), .resp_data(resp_data),
    .resp_exc(resp_exc), .busy(busy),
    .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs
  // settle well away from the edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_req(input int i, input logic sq,
                         input logic [64:0] a, input logic [64:0] b,
                         input logic [2:0] rm, input logic [TW-1:0] tg);
    req_valid[i]        = 1'b1;
    req_sqrt[i]         = sq;
    req_a[i*65 +: 65]   = a;
    req_b[i*65 +: 65]   = b;
    req_rm[i*3 +: 3]    = rm;
    req_tag[i*TW +: TW] = tg;
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush = 1'b0;
    resp_ready = 1'b0;
    unit_out_valid_div = 1'b0;
    unit_out_valid_sqrt = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic pulse(input logic sq, input logic [64:0] d,
                       input logic [4:0] e);
    unit_out_valid_div  = ~sq;
    unit_out_valid_sqrt = sq;
    unit_out = d;
    unit_exc = e;
    tick();
    unit_out_valid_div  = 1'b0;
    unit_out_valid_sqrt = 1'b0;
    #1;
  endtask

  initial begin
    // reset state
    tick();
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_rdata", resp_data, 0);
    chk("rst_uiv", unit_in_valid, 0);

    // single div, issue cycle 0, result cycle 20
    set_req(0, 1'b0, ONE, TWO, 3'd0, 5'd3);
    #1;
    chk("sd_uiv", unit_in_valid, 1);
    chk("sd_rdy", req_ready, 2'b01);
    chk("sd_a", unit_a, ONE);
    chk("sd_b", unit_b, TWO);
    chk("sd_sqrt", unit_sqrt, 0);
    tick();
    req_valid = '0;
    #1;
    chk("sd_busy", busy, 1);
    repeat (19) tick();
    unit_out_valid_div = 1'b1;
    unit_out = HALF;
    unit_exc = 5'd0;
    #1;
    chk("sd_rv20", resp_valid, 0);
    tick();
    unit_out_valid_div = 1'b0;
    #1;
    chk("sd_rv21", resp_valid, 1);
    chk("sd_id", resp_id, 0);
    chk("sd_tag", resp_tag, 3);
    chk("sd_issq", resp_is_sqrt, 0);
    chk("sd_data", resp_data, HALF);
    chk("sd_exc", resp_exc, 0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("sd_done_rv", resp_valid, 0);
    chk("sd_done_busy", busy, 0);

    // fairness: both held, grant 0,1,0,1 then wrap to 0
    do_reset();
    set_req(0, 1'b0, ONE, ONE, 3'd1, 5'd10);
    set_req(1, 1'b0, TWO, TWO, 3'd2, 5'd21);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("fair_gnt", req_ready, (k % 2) ? 2'b10 : 2'b01);
      chk("fair_rm", unit_rm, (k % 2) ? 3'd2 : 3'd1);
      tick();
      if (k == 0) chk("fair_busy_rdy", req_ready, 2'b00);
      pulse(1'b0, 65'(k + 100), 5'd0);
      chk("fair_id", resp_id, k % 2);
      chk("fair_tag", resp_tag, (k % 2) ? 5'd21 : 5'd10);
      chk("fair_data", resp_data, 65'(k + 100));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      #1;
    end
    chk("fair_wrap", req_ready, 2'b01);

    // backpressure on a sqrt from requester 1
    do_reset();
    set_req(1, 1'b1, TWO, 65'd0, 3'd4, 5'd7);
    #1;
    chk("bp_rdy", req_ready, 2'b10);
    chk("bp_sqrt", unit_sqrt, 1);
    tick();
    req_valid = '0;
    set_req(0, 1'b0, ONE, TWO, 3'd0, 5'd1);
    pulse(1'b1, 65'h1_2345, 5'b00001);
    for (int c = 0; c < 10; c++) begin
      chk("bp_rv", resp_valid, 1);
      chk("bp_data", resp_data, 65'h1_2345);
      chk("bp_uiv", unit_in_valid, 0);
      chk("bp_rdy0", req_ready, 2'b00);
      tick();
    end
    chk("bp_exc", resp_exc, 5'b00001);
    chk("bp_issq", resp_is_sqrt, 1);
    chk("bp_id", resp_id, 1);
    resp_ready = 1'b1;
    #1;
    chk("bp_noissue", unit_in_valid, 0);
    tick();
    resp_ready = 1'b0;
    #1;
    chk("bp_rv_low", resp_valid, 0);
    chk("bp_resume", req_ready, 2'b01);

    // flush in BUSY at cycle 5, result at 20 is dropped
    do_reset();
    set_req(0, 1'b0, ONE, TWO, 3'd0, 5'd2);
    tick();
    req_valid = '0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (14) tick();
    chk("fl_busy20", busy, 1);
    pulse(1'b0, HALF, 5'd0);
    chk("fl_rv", resp_valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_perr", protocol_err, 0);
    set_req(1, 1'b0, TWO, ONE, 3'd0, 5'd9);
    #1;
    chk("fl_next", req_ready, 2'b10);
    tick();
    chk("fl_next_busy", busy, 1);

    // flush in RESP wins over resp_ready; flush in IDLE blocks issue
    req_valid = '0;
    pulse(1'b0, TWO, 5'd0);
    chk("fr_rv", resp_valid, 1);
    flush = 1'b1;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    set_req(0, 1'b0, ONE, ONE, 3'd0, 5'd4);
    #1;
    chk("fr_rv_low", resp_valid, 0);
    chk("fi_block", unit_in_valid, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fi_busy", busy, 0);
    chk("fi_uiv", unit_in_valid, 1);

    // type mismatch: sqrt op answered with a div pulse
    do_reset();
    set_req(0, 1'b1, TWO, 65'd0, 3'd0, 5'd6);
    tick();
    req_valid = '0;
    tick();
    pulse(1'b0, ONE, 5'b00010);
    chk("tm_perr", protocol_err, 1);
    chk("tm_rv", resp_valid, 1);
    chk("tm_issq", resp_is_sqrt, 1);
    chk("tm_tag", resp_tag, 6);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("tm_sticky", protocol_err, 1);
    // stray output in IDLE also flags
    do_reset();
    chk("tm_clr", protocol_err, 0);
    pulse(1'b1, ONE, 5'd0);
    chk("idle_stray", protocol_err, 1);

    // reset mid-BUSY
    do_reset();
    set_req(1, 1'b0, ONE, TWO, 3'd0, 5'd8);
    tick();
    req_valid = '0;
    repeat (3) tick();
    do_reset();
    chk("rb_busy", busy, 0);
    chk("rb_rv", resp_valid, 0);
    set_req(1, 1'b0, ONE, TWO, 3'd0, 5'd8);
    #1;
    chk("rb_accept", req_ready, 2'b10);
    tick();
    chk("rb_busy2", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
